// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link: FSM states, line levels
// and the default word width / bit period used by both transmitter and receiver.
package serial_pkg;

  localparam int DEFAULT_W            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // A modulo-n counter still needs one bit when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of
// each line bit. A synchronous clear holds the count at zero.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic end_of_bit_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last      = (cnt_q == LAST);
  assign end_of_bit_o = at_last && !clear_i;

  // Wrap on the last cycle; with a one-cycle period the count never leaves zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, data LSB-first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         valid,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  tx_state_e     state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic          end_of_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == IDLE),
    .end_of_bit_o (end_of_bit)
  );

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign done  = (state_q == STOP) && end_of_bit;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d   = data_in;
          bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^data_in;
`endif
          state_d   = START;
        end
      end
      START: begin
        if (end_of_bit) state_d = DATA;
      end
      DATA: begin
        if (end_of_bit) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (end_of_bit) state_d = STOP;
      end
`endif
      STOP: begin
        if (end_of_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded purely from registered state.
  always_comb begin
    tx = LINE_IDLE;
    case (state_q)
      START:   tx = LINE_START;
      DATA:    tx = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx = parity_q;
`endif
      default: tx = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a W=8/CLKS_PER_BIT=4 instance driven from a
// vector table through an expected-frame queue, plus a W=1/CLKS_PER_BIT=1 instance.
module tb_serial_tx;

  localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam int NBITS1 = 4;
`else
  localparam int NBITS  = 10;
  localparam int NBITS1 = 3;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] lineSeq;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       ready, tx, busy, done;
  logic       valid1 = 1'b0;
  logic [0:0] data1 = 1'b0;
  logic       ready1, tx1, busy1, done1;

  vec_t vectors[6];
  vec_t vec11, vec22, vecFF, vec0F;
  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.W(8), .CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (dataIn),
    .valid   (valid),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  serial_tx #(.W(1), .CLKS_PER_BIT(1)) dutCorner (
    .clk     (clk),
    .rst     (rst),
    .data_in (data1),
    .valid   (valid1),
    .ready   (ready1),
    .tx      (tx1),
    .busy    (busy1),
    .done    (done1)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Line bit b of a frame in time order: start + 8 data, then parity, then stop.
  function automatic logic expBit(input vec_t v, input int b);
    if (b < 9) return v.lineSeq[9 - b];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return v.par;
`endif
    return v.lineSeq[0];
  endfunction

  // Called at a negedge; returns just after the accept edge.
  task automatic applyStimulus(input logic [7:0] d, input bit doPush, input vec_t v);
    int n;
    dataIn = d;
    valid  = 1'b1;
    if (doPush) expQ.push_back(v);
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptReady", ready, 1'b1);
    @(posedge clk);
  endtask

  // Follows one frame from the cycle after accept through the cycle after done.
  task automatic checkFrame(input bit chain, input logic [7:0] newData, input vec_t newV);
    vec_t v;
    int   f;
    f = NBITS * C;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending frame");
      return;
    end
    v = expQ.pop_front();
    for (int t = 1; t <= f + 1; t++) begin
      @(negedge clk);
      if (t <= f) begin
        checkOutput($sformatf("busy t%0d", t), busy, 1'b1);
        checkOutput($sformatf("ready t%0d", t), ready, 1'b0);
        checkOutput($sformatf("done t%0d", t), done, t == f);
        checkOutput($sformatf("tx %02h t%0d", v.data, t), tx, expBit(v, (t - 1) / C));
      end else begin
        checkOutput("readyAfter", ready, 1'b1);
        checkOutput("doneAfter", done, 1'b0);
        checkOutput("txIdleAfter", tx, 1'b1);
      end
      if (t == 1) begin
        dataIn = newData;
        if (chain) expQ.push_back(newV);
        else valid = 1'b0;
      end
    end
  endtask

  task automatic sendCorner(input logic d);
    checkOutput("cornerReady", ready1, 1'b1);
    data1  = d;
    valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    data1  = ~d;
    for (int t = 1; t <= NBITS1 + 1; t++) begin
      if (t > 1) @(negedge clk);
      if (t == 1)            checkOutput("cornerStart", tx1, 1'b0);
      else if (t == 2)       checkOutput("cornerData", tx1, d);
      else if (t < NBITS1)   checkOutput("cornerParity", tx1, d);
      else                   checkOutput("cornerStop", tx1, 1'b1);
      if (t <= NBITS1) checkOutput($sformatf("cornerDone t%0d", t), done1, t == NBITS1);
      else             checkOutput("cornerReadyAfter", ready1, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vectors[1] = '{8'h07, 10'b0111000001, 1'b1};
    vectors[2] = '{8'h03, 10'b0110000001, 1'b0};
    vectors[3] = '{8'h80, 10'b0000000011, 1'b1};
    vectors[4] = '{8'h00, 10'b0000000001, 1'b0};
    vectors[5] = '{8'h3C, 10'b0001111001, 1'b0};
    vec11 = '{8'h11, 10'b0100010001, 1'b0};
    vec22 = '{8'h22, 10'b0010001001, 1'b0};
    vecFF = '{8'hFF, 10'b0111111111, 1'b0};
    vec0F = '{8'h0F, 10'b0111100001, 1'b0};

    // Reset held three cycles, then two idle cycles after release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rstTx", tx, 1'b1);
      checkOutput("rstReady", ready, 1'b1);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstDone", done, 1'b0);
      checkOutput("rstCornerTx", tx1, 1'b1);
      checkOutput("rstCornerBusy", busy1, 1'b0);
      if (i == 2) rst = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      $display("[TB] frame %02h", vectors[i].data);
      applyStimulus(vectors[i].data, 1'b1, vectors[i]);
      checkFrame(1'b0, ~vectors[i].data, vectors[i]);
    end

    $display("[TB] handshake with valid held high");
    applyStimulus(8'h11, 1'b1, vec11);
    checkFrame(1'b1, 8'h22, vec22);
    applyStimulus(8'h22, 1'b0, vec22);
    checkFrame(1'b0, 8'hEE, vec22);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'hFF, 1'b0, vecFF);
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      if (t == 1) valid = 1'b0;
    end
    checkOutput("abortBit3", tx, 1'b1);
    rst    = 1'b1;
    valid  = 1'b1;
    dataIn = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abortTx", tx, 1'b1);
      checkOutput("abortReady", ready, 1'b1);
      checkOutput("abortBusy", busy, 1'b0);
      checkOutput("abortDone", done, 1'b0);
    end
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    checkOutput("postAbortIdle", busy, 1'b0);
    applyStimulus(8'h0F, 1'b1, vec0F);
    checkFrame(1'b0, 8'hA0, vec0F);

    $display("[TB] W=1 CLKS_PER_BIT=1");
    sendCorner(1'b1);
    sendCorner(1'b0);

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got %0d leftover frames, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
